// File: rtl/write_resp_xbar_if.sv
// Bundle of the bank-side and requester-side write response channels.
// Handshake: a channel transfers on the rising edge where vld && rdy are both
// high; the sender holds vld and payload stable until that edge.
interface write_resp_xbar_if #(
  parameter int W_REQ_NUM          = 8,
  parameter int SRC_WIDTH          = $clog2(W_REQ_NUM),
  parameter int TXNID_WIDTH        = 8,
  parameter int SIDEBAND_WIDTH     = 4,
  parameter int DB_ENTRY_IDX_WIDTH = 4
);
  logic [3:0]                                bank_resp_vld;
  logic [3:0]                                bank_resp_rdy;
  logic [3:0][SRC_WIDTH-1:0]                 bank_resp_src;
  logic [3:0][TXNID_WIDTH-1:0]               bank_resp_txnid;
  logic [3:0][SIDEBAND_WIDTH-1:0]            bank_resp_sideband;
  logic [3:0][DB_ENTRY_IDX_WIDTH-1:0]        bank_resp_db_idx;
  logic [W_REQ_NUM-1:0]                      wr_resp_vld;
  logic [W_REQ_NUM-1:0]                      wr_resp_rdy;
  logic [W_REQ_NUM-1:0][TXNID_WIDTH-1:0]     wr_resp_txnid;
  logic [W_REQ_NUM-1:0][SIDEBAND_WIDTH-1:0]  wr_resp_sideband;
  logic [3:0]                                dealloc_vld;
  logic [3:0][DB_ENTRY_IDX_WIDTH-1:0]        dealloc_idx;
  logic                                      err_src;

  // Environment side: banks, requesters and the WDB allocator.
  modport master (
    output bank_resp_vld, bank_resp_src, bank_resp_txnid, bank_resp_sideband,
           bank_resp_db_idx, wr_resp_rdy,
    input  bank_resp_rdy, wr_resp_vld, wr_resp_txnid, wr_resp_sideband,
           dealloc_vld, dealloc_idx, err_src
  );

  // Crossbar side.
  modport slave (
    input  bank_resp_vld, bank_resp_src, bank_resp_txnid, bank_resp_sideband,
           bank_resp_db_idx, wr_resp_rdy,
    output bank_resp_rdy, wr_resp_vld, wr_resp_txnid, wr_resp_sideband,
           dealloc_vld, dealloc_idx, err_src
  );
endinterface

// File: rtl/write_resp_xbar.sv
// Write response return crossbar: 4 banks -> W_REQ_NUM requesters.
// Each bank has a 2-entry FIFO; each requester has a 1-entry output register
// fed by a round-robin pick among the bank FIFO heads addressed to it.
// Popping a head frees its WDB entry through a same-cycle dealloc pulse.
module write_resp_xbar #(
  parameter int W_REQ_NUM          = 8,
  parameter int SRC_WIDTH          = $clog2(W_REQ_NUM),
  parameter int FIFO_DEPTH         = 2,
  parameter int TXNID_WIDTH        = 8,
  parameter int SIDEBAND_WIDTH     = 4,
  parameter int DB_ENTRY_IDX_WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  write_resp_xbar_if.slave bus
);
  localparam int NB = 4;

  typedef struct packed {
    logic [SRC_WIDTH-1:0]          src;
    logic [TXNID_WIDTH-1:0]        txnid;
    logic [SIDEBAND_WIDTH-1:0]     sideband;
    logic [DB_ENTRY_IDX_WIDTH-1:0] db_idx;
  } entry_t;

  entry_t                  mem_q [NB][2];
  logic [NB-1:0]           wr_ptr_q, rd_ptr_q;
  logic [NB-1:0][1:0]      cnt_q;
  entry_t                  head [NB];
  entry_t                  entry_in [NB];
  logic [NB-1:0]           nonempty, head_bad, rdy, push, pop;

  logic [W_REQ_NUM-1:0]                      vld_q;
  logic [W_REQ_NUM-1:0][TXNID_WIDTH-1:0]     txnid_q;
  logic [W_REQ_NUM-1:0][SIDEBAND_WIDTH-1:0]  sb_q;
  logic [W_REQ_NUM-1:0][1:0]                 ptr_q;
  logic                                      err_q;

  logic [W_REQ_NUM-1:0]                      load_en, gnt_any, take;
  logic [W_REQ_NUM-1:0][1:0]                 gnt_bank;
  logic [W_REQ_NUM-1:0][NB-1:0]              req;

  // FIFO heads, ready flags and classification of each head.
  always_comb begin
    for (int b = 0; b < NB; b++) begin
      head[b]     = mem_q[b][rd_ptr_q[b]];
      entry_in[b] = '{src:      bus.bank_resp_src[b],
                      txnid:    bus.bank_resp_txnid[b],
                      sideband: bus.bank_resp_sideband[b],
                      db_idx:   bus.bank_resp_db_idx[b]};
      nonempty[b] = (cnt_q[b] != 2'd0);
      rdy[b]      = (cnt_q[b] < 2'(FIFO_DEPTH));
      push[b]     = bus.bank_resp_vld[b] && rdy[b];
      head_bad[b] = nonempty[b] &&
                    ({1'b0, head[b].src} >= (SRC_WIDTH+1)'(W_REQ_NUM));
    end
  end

  // Per-requester request vectors and round-robin grant from ptr_q upward.
  always_comb begin
    logic [1:0] idx;
    idx      = '0;
    req      = '0;
    gnt_any  = '0;
    gnt_bank = '0;
    for (int r = 0; r < W_REQ_NUM; r++) begin
      load_en[r] = !vld_q[r] || bus.wr_resp_rdy[r];
      for (int b = 0; b < NB; b++)
        req[r][b] = nonempty[b] && (head[b].src == SRC_WIDTH'(r));
      for (int k = 0; k < NB; k++) begin
        idx = ptr_q[r] + 2'(k);
        if (!gnt_any[r] && req[r][idx]) begin
          gnt_any[r]  = 1'b1;
          gnt_bank[r] = idx;
        end
      end
      take[r] = gnt_any[r] && load_en[r];
    end
  end

  // A head pops when its requester takes it, or immediately if its src is out of range.
  always_comb begin
    pop = head_bad;
    for (int r = 0; r < W_REQ_NUM; r++)
      for (int b = 0; b < NB; b++)
        if (take[r] && gnt_bank[r] == 2'(b)) pop[b] = 1'b1;
  end

  // Bank FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (push[b]) begin
          mem_q[b][wr_ptr_q[b]] <= entry_in[b];
          wr_ptr_q[b]           <= ~wr_ptr_q[b];
        end
        if (pop[b]) rd_ptr_q[b] <= ~rd_ptr_q[b];
        case ({push[b], pop[b]})
          2'b10:   cnt_q[b] <= cnt_q[b] + 2'd1;
          2'b01:   cnt_q[b] <= cnt_q[b] - 2'd1;
          default: cnt_q[b] <= cnt_q[b];
        endcase
      end
    end
  end

  // Requester output registers, round-robin pointers and sticky bad-src flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      txnid_q <= '0;
      sb_q    <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int r = 0; r < W_REQ_NUM; r++) begin
        if (load_en[r]) begin
          vld_q[r] <= gnt_any[r];
          if (gnt_any[r]) begin
            txnid_q[r] <= head[gnt_bank[r]].txnid;
            sb_q[r]    <= head[gnt_bank[r]].sideband;
            ptr_q[r]   <= gnt_bank[r] + 2'd1;
          end
        end
      end
      if (|head_bad) err_q <= 1'b1;
    end
  end

  // Outputs; dealloc is suppressed while rst is high so discarded entries are never freed twice.
  always_comb begin
    for (int b = 0; b < NB; b++) begin
      bus.dealloc_vld[b] = pop[b] && !rst;
      bus.dealloc_idx[b] = (pop[b] && !rst) ? head[b].db_idx : '0;
    end
  end

  assign bus.bank_resp_rdy    = rdy;
  assign bus.wr_resp_vld      = vld_q;
  assign bus.wr_resp_txnid    = txnid_q;
  assign bus.wr_resp_sideband = sb_q;
  assign bus.err_src          = err_q;
endmodule

// File: tb/tb_write_resp_xbar.sv
// Directed bench for write_resp_xbar with 6 requesters (non-power-of-2 so an
// out-of-range src can be exercised).
module tb_write_resp_xbar;
  localparam int W  = 6;
  localparam int SW = 3;
  localparam int TW = 8;
  localparam int BW = 4;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  write_resp_xbar_if #(.W_REQ_NUM(W), .SRC_WIDTH(SW), .TXNID_WIDTH(TW),
                       .SIDEBAND_WIDTH(BW), .DB_ENTRY_IDX_WIDTH(DW)) bus ();

  write_resp_xbar #(.W_REQ_NUM(W), .SRC_WIDTH(SW), .FIFO_DEPTH(2), .TXNID_WIDTH(TW),
                    .SIDEBAND_WIDTH(BW), .DB_ENTRY_IDX_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic drive_bank(input int b, input int s, input int txn, input int sb, input int idx);
    bus.bank_resp_vld[b]      = 1'b1;
    bus.bank_resp_src[b]      = SW'(s);
    bus.bank_resp_txnid[b]    = TW'(txn);
    bus.bank_resp_sideband[b] = BW'(sb);
    bus.bank_resp_db_idx[b]   = DW'(idx);
  endtask

  task automatic clear_banks();
    bus.bank_resp_vld = '0;
  endtask

  // One response from bank b to requester s, checked through delivery.
  task automatic single(input int b, input int s, input int txn, input int sb, input int idx);
    drive_bank(b, s, txn, sb, idx);
    tick(); clear_banks(); #1;
    chk("single_dealloc_vld", 32'(bus.dealloc_vld), 32'(1 << b));
    chk("single_dealloc_idx", 32'(bus.dealloc_idx[b]), 32'(idx));
    chk("single_wr_vld_early", 32'(bus.wr_resp_vld), 32'd0);
    tick(); #1;
    chk("single_wr_vld", 32'(bus.wr_resp_vld), 32'(1 << s));
    chk("single_txnid", 32'(bus.wr_resp_txnid[s]), 32'(txn));
    chk("single_sideband", 32'(bus.wr_resp_sideband[s]), 32'(sb));
    chk("single_dealloc_quiet", 32'(bus.dealloc_vld), 32'd0);
    tick(); #1;
    chk("single_wr_vld_done", 32'(bus.wr_resp_vld), 32'd0);
  endtask

  // All four banks to requester 3 at once; expected service order o0..o3.
  task automatic rr_burst(input int o0, input int o1, input int o2, input int o3);
    int ord[4];
    ord = '{o0, o1, o2, o3};
    for (int b = 0; b < 4; b++) drive_bank(b, 3, 'h10 + b, b + 1, b);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) clear_banks();
      #1;
      if (c <= 4) begin
        chk("rr_dealloc_vld", 32'(bus.dealloc_vld), 32'(1 << ord[c-1]));
        chk("rr_dealloc_idx", 32'(bus.dealloc_idx[ord[c-1]]), 32'(ord[c-1]));
      end else begin
        chk("rr_dealloc_quiet", 32'(bus.dealloc_vld), 32'd0);
      end
      if (c >= 2 && c <= 5) begin
        chk("rr_wr_vld", 32'(bus.wr_resp_vld), 32'h08);
        chk("rr_txnid", 32'(bus.wr_resp_txnid[3]), 32'('h10 + ord[c-2]));
        chk("rr_sideband", 32'(bus.wr_resp_sideband[3]), 32'(ord[c-2] + 1));
      end else begin
        chk("rr_wr_vld_idle", 32'(bus.wr_resp_vld), 32'd0);
      end
    end
  endtask

  initial begin
    bus.bank_resp_vld      = '0;
    bus.bank_resp_src      = '0;
    bus.bank_resp_txnid    = '0;
    bus.bank_resp_sideband = '0;
    bus.bank_resp_db_idx   = '0;
    bus.wr_resp_rdy        = '1;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    tick(); #1;
    chk("reset_bank_rdy", 32'(bus.bank_resp_rdy), 32'hF);
    chk("reset_wr_vld", 32'(bus.wr_resp_vld), 32'd0);
    chk("reset_dealloc", 32'(bus.dealloc_vld), 32'd0);
    chk("reset_dealloc_idx", 32'(bus.dealloc_idx), 32'd0);
    chk("reset_err", 32'(bus.err_src), 32'd0);
    chk("reset_txnid", 32'(bus.wr_resp_txnid), 32'd0);

    // Single response: bank 2 -> requester 5
    single(2, 5, 'h3A, 'h9, 7);

    // Round-robin: pointer at 0, twice, then preset to 2 via bank 1
    rr_burst(0, 1, 2, 3);
    rr_burst(0, 1, 2, 3);
    single(1, 3, 'h77, 'h2, 4);
    rr_burst(2, 3, 0, 1);

    // Backpressure on requester 1, bank 0 sends four responses
    bus.wr_resp_rdy = 6'h3D;
    drive_bank(0, 1, 'h40, 1, 8);                 // A
    tick(); drive_bank(0, 1, 'h41, 2, 9); #1;     // B
    chk("bp_dealloc_a", 32'(bus.dealloc_vld), 32'h1);
    chk("bp_dealloc_a_idx", 32'(bus.dealloc_idx[0]), 32'd8);
    tick(); drive_bank(0, 1, 'h42, 3, 10); #1;    // C
    chk("bp_bank_rdy_2", 32'(bus.bank_resp_rdy[0]), 32'd1);
    chk("bp_out_a", 32'(bus.wr_resp_txnid[1]), 32'h40);
    tick(); clear_banks(); #1;
    chk("bp_bank_rdy_full", 32'(bus.bank_resp_rdy[0]), 32'd0);
    chk("bp_wr_vld_held", 32'(bus.wr_resp_vld), 32'h02);
    chk("bp_txnid_held", 32'(bus.wr_resp_txnid[1]), 32'h40);
    chk("bp_no_dealloc", 32'(bus.dealloc_vld), 32'd0);
    tick(); #1;
    chk("bp_txnid_stable", 32'(bus.wr_resp_txnid[1]), 32'h40);
    chk("bp_sideband_stable", 32'(bus.wr_resp_sideband[1]), 32'h1);
    chk("bp_still_full", 32'(bus.bank_resp_rdy[0]), 32'd0);
    tick(); bus.wr_resp_rdy = '1; #1;
    chk("bp_release_dealloc_b", 32'(bus.dealloc_idx[0]), 32'd9);
    chk("bp_release_out_a", 32'(bus.wr_resp_txnid[1]), 32'h40);
    tick(); #1;
    chk("bp_rdy_back", 32'(bus.bank_resp_rdy[0]), 32'd1);
    chk("bp_out_b", 32'(bus.wr_resp_txnid[1]), 32'h41);
    chk("bp_dealloc_c", 32'(bus.dealloc_idx[0]), 32'd10);
    drive_bank(0, 1, 'h43, 4, 11);                // D
    tick(); clear_banks(); #1;
    chk("bp_out_c", 32'(bus.wr_resp_txnid[1]), 32'h42);
    chk("bp_dealloc_d", 32'(bus.dealloc_idx[0]), 32'd11);
    tick(); #1;
    chk("bp_out_d", 32'(bus.wr_resp_txnid[1]), 32'h43);
    chk("bp_out_d_vld", 32'(bus.wr_resp_vld), 32'h02);
    tick(); #1;
    chk("bp_drained", 32'(bus.wr_resp_vld), 32'd0);
    chk("bp_rdy_final", 32'(bus.bank_resp_rdy), 32'hF);

    // Parallel routing: bank b -> requester b
    for (int b = 0; b < 4; b++) drive_bank(b, b, 'h50 + b, 5 + b, 12 + b);
    tick(); clear_banks(); #1;
    chk("par_dealloc", 32'(bus.dealloc_vld), 32'hF);
    chk("par_dealloc_idx", 32'(bus.dealloc_idx), 32'hFEDC);
    tick(); #1;
    chk("par_wr_vld", 32'(bus.wr_resp_vld), 32'h0F);
    chk("par_txnid", 32'(bus.wr_resp_txnid[3:0]), 32'h53525150);
    chk("par_sideband", 32'(bus.wr_resp_sideband[3:0]), 32'h8765);
    tick(); #1;
    chk("par_done", 32'(bus.wr_resp_vld), 32'd0);

    // Bad src: bank 1 -> requester 7 (out of range for 6 requesters)
    drive_bank(1, 7, 'h66, 0, 5);
    tick(); clear_banks(); #1;
    chk("bad_dealloc", 32'(bus.dealloc_vld), 32'h2);
    chk("bad_dealloc_idx", 32'(bus.dealloc_idx[1]), 32'd5);
    chk("bad_err_not_yet", 32'(bus.err_src), 32'd0);
    tick(); #1;
    chk("bad_err_set", 32'(bus.err_src), 32'd1);
    chk("bad_no_delivery", 32'(bus.wr_resp_vld), 32'd0);
    chk("bad_dealloc_once", 32'(bus.dealloc_vld), 32'd0);
    tick(); tick(); #1;
    chk("bad_err_sticky", 32'(bus.err_src), 32'd1);
    chk("bad_bank_rdy", 32'(bus.bank_resp_rdy), 32'hF);

    // Reset with three responses buffered toward requester 2
    bus.wr_resp_rdy = 6'h3B;
    drive_bank(2, 2, 'h70, 0, 1);
    tick(); drive_bank(2, 2, 'h71, 0, 2); #1;
    tick(); drive_bank(2, 2, 'h72, 0, 3); #1;
    tick(); clear_banks(); rst = 1'b1; #1;
    chk("rst_pre_full", 32'(bus.bank_resp_rdy[2]), 32'd0);
    chk("rst_pre_vld", 32'(bus.wr_resp_vld), 32'h04);
    chk("rst_no_dealloc_during", 32'(bus.dealloc_vld), 32'd0);
    tick(); rst = 1'b0; bus.wr_resp_rdy = '1; #1;
    chk("rst_wr_vld", 32'(bus.wr_resp_vld), 32'd0);
    chk("rst_bank_rdy", 32'(bus.bank_resp_rdy), 32'hF);
    chk("rst_dealloc", 32'(bus.dealloc_vld), 32'd0);
    chk("rst_err_cleared", 32'(bus.err_src), 32'd0);
    tick(); #1;
    chk("rst_after_vld", 32'(bus.wr_resp_vld), 32'd0);
    chk("rst_after_dealloc", 32'(bus.dealloc_vld), 32'd0);

    // Pointer reset check: fresh burst after rst starts at bank 0
    rr_burst(0, 1, 2, 3);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/write_resp_xbar.md
# write_resp_xbar

Return-path crossbar for vector_cache write completions. It accepts write responses from the 4 cache banks and buffers them per bank. It routes each response to one of W_REQ_NUM requester ports by source id, arbitrating round-robin per requester. When a response is delivered, it frees the write-data-buffer entry that the forward write path allocated. It sits between the bank write pipelines and the requester-side write response channels, mirroring the forward N-to-4 write request crossbar.

## Interface
Parameters:
- W_REQ_NUM, 8, number of requester ports (≥2)
- SRC_WIDTH, $clog2(W_REQ_NUM), source-id width
- FIFO_DEPTH, 2, per-bank input buffer depth (fixed 2 for this revision)
- TXNID_WIDTH, SIDEBAND_WIDTH, DB_ENTRY_IDX_WIDTH, from vector_cache_pkg

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- bank_resp_vld  in  [3:0]  bank response valid
- bank_resp_rdy  out  [3:0]  bank response ready (= per-bank FIFO not full, registered)
- bank_resp_src  in  SRC_WIDTH ×4  destination requester id
- bank_resp_txnid  in  TXNID_WIDTH ×4  original write txnid
- bank_resp_sideband  in  SIDEBAND_WIDTH ×4  original sideband
- bank_resp_db_idx  in  DB_ENTRY_IDX_WIDTH ×4  WDB entry to free
- wr_resp_vld  out  [W_REQ_NUM-1:0]  response valid to requester
- wr_resp_rdy  in  [W_REQ_NUM-1:0]  requester ready
- wr_resp_txnid  out  TXNID_WIDTH ×W_REQ_NUM
- wr_resp_sideband  out  SIDEBAND_WIDTH ×W_REQ_NUM
- dealloc_vld  out  [3:0]  one-cycle pulse, WDB entry freed for bank b
- dealloc_idx  out  DB_ENTRY_IDX_WIDTH ×4  entry freed
- err_src  out  1  sticky: response received with src ≥ W_REQ_NUM

## Operation
- Per bank: 2-entry FIFO of {src, txnid, sideband, db_idx}. Push on bank_resp_vld && bank_resp_rdy. Count 0..2. bank_resp_rdy = (count<2), derived from registered count, no combinational path from pop.
- Per requester r: request vector req_r[b] = FIFO_b nonempty && head_b.src == r. A FIFO head targets exactly one requester, so no cross-requester conflict exists.
- Per requester output register (1 entry). Load enable = !wr_resp_vld[r] || wr_resp_rdy[r].
- Round-robin per requester: ptr_r in 0..3, reset 0. Search order ptr_r, ptr_r+1, … mod 4. On grant to bank b with load enable, ptr_r ← (b+1) mod 4. Pointer is unchanged when there is no grant.
- Grant pops FIFO_b, loads {txnid, sideband} into output r, and pulses dealloc_vld[b] with dealloc_idx[b] = head_b.db_idx in the same cycle as the pop.
- Invalid src (≥ W_REQ_NUM, non-power-of-2 config only): the head pops unconditionally the cycle it is at the head, dealloc still pulses, nothing is delivered, err_src sets and stays set until rst.
- Push and pop on the same FIFO in the same cycle are legal. Count is unchanged, and a push while full is not possible (rdy low).

## Timing
- Reset values: bank_resp_rdy=4'hF (the first cycle after rst deasserts), wr_resp_vld=0, dealloc_vld=0, err_src=0, FIFOs empty, all ptr_r=0, data outputs 0.
- Latency: response accepted at edge T → at FIFO head in cycle T+1 → output register loaded at edge T+2. wr_resp_vld is high in cycle after edge T+2: 2 cycles minimum. dealloc_vld is high in cycle T+1.
- Throughput: 1 response/cycle/requester with wr_resp_rdy held high. 4 responses/cycle aggregate when all src differ.
- Output handshake: wr_resp_vld is held with stable payload until wr_resp_rdy. Transfer on vld&&rdy; the next response can load in the same edge.
- Bank handshake: a full FIFO drops rdy. rdy reasserts the cycle after a pop.
- rst mid-operation: all buffered responses are discarded, no dealloc pulses are issued for them, and outputs return to reset values in the next cycle. The WDB allocator is reset with the same rst.

## Test plan
- Single response: bank 2 src=5 txnid=0x3A db_idx=7 at T → dealloc_vld[2]=1 idx=7 at T+1; wr_resp_vld[5]=1 txnid=0x3A at T+2. Other outputs stay 0.
- Round-robin: all 4 banks src=3 at the same cycle, rdy high → requester 3 receives banks 0,1,2,3 on consecutive cycles. Second identical burst with ptr=0 → same order. With ptr_3 preset to 2 via a prior single grant from bank 1 → order 2,3,0,1.
- Backpressure: wr_resp_rdy[1]=0, bank 0 sends 4 responses src=1 → 1 in output register, 2 in FIFO, bank_resp_rdy[0]=0 after the 3rd push. Raise rdy → all 4 delivered in order, rdy[0] returns high.
- Parallel routing: banks 0..3 src=0,1,2,3 in the same cycle → all four wr_resp_vld high together 2 cycles later, four dealloc pulses in one cycle.
- Bad src, W_REQ_NUM=6: bank 1 src=7 → dealloc_vld[1] pulses, no wr_resp_vld, err_src=1 and held.
- Reset mid-traffic: assert rst with 3 responses buffered → next cycle all wr_resp_vld=0, bank_resp_rdy=4'hF, no dealloc pulses.
